// File: rtl/asrv32_mem_responder_pkg.sv
// Shared definitions for the asrv32 memory responder: FSM states, byte-lane geometry
// and the ASRV32_MEM_ERR_EN guard that turns on out-of-range error reporting.
package asrv32_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;

`ifdef ASRV32_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

endpackage

// File: rtl/asrv32_mem_array.sv
// Word-organised RAM with one synchronous read/write port and per-byte-lane write enables.
// Contents are deliberately not reset.
module asrv32_mem_array
  import asrv32_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic                       we,
  input  logic [LANES-1:0]           wstrb,
  input  logic [LANES*LANE_W-1:0]    wdata,
  output logic [LANES*LANE_W-1:0]    rdata
);

  logic [LANES*LANE_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int lane = 0; lane < LANES; lane++) begin
      if (we && wstrb[lane]) begin
        mem[addr][lane*LANE_W +: LANE_W] <= wdata[lane*LANE_W +: LANE_W];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/asrv32_mem_responder.sv
// Strobe/ack bus responder in front of asrv32_mem_array, with configurable wait states.
// Defining ASRV32_MEM_ERR_EN adds o_rsp_err and suppresses out-of-range accesses.
module asrv32_mem_responder
  import asrv32_mem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_stb,
  input  logic             i_req_we,
  input  logic [31:0]      i_req_addr,
  input  logic [31:0]      i_req_wdata,
  input  logic [LANES-1:0] i_req_wstrb,
  output logic             o_req_ack,
  output logic [31:0]      o_rsp_rdata,
  output logic             o_busy
`ifdef ASRV32_MEM_ERR_EN
  ,
  output logic             o_rsp_err
`endif
);

  localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;

  state_t                state;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [31:0]           req_wdata;
  logic [LANES-1:0]      req_wstrb;
  logic                  req_oor;

  logic [32:0]           offset;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic                  acc_oor;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  ram_we;
  logic [31:0]           ram_rdata;
  logic                  unused_offset;

  // The extra top bit of offset catches addresses below BASE_ADDR as a borrow.
  assign offset        = {1'b0, i_req_addr} - {1'b0, BASE_ADDR};
  assign acc_idx       = offset[ADDR_WIDTH+1:2];
  assign unused_offset = ^{offset[32:ADDR_WIDTH+2], offset[1:0]};

  if (ERR_EN) begin : g_range
    assign acc_oor = (offset >> (ADDR_WIDTH + 2)) != '0;
  end else begin : g_wrap
    assign acc_oor = 1'b0;
  end

  // The RAM reads the incoming address while idle so data is ready even with zero wait states.
  assign ram_idx = (state == ST_IDLE) ? acc_idx : req_idx;
  assign ram_we  = (state == ST_RESP) && req_we && !req_oor;

  asrv32_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (i_clk),
    .addr  (ram_idx),
    .we    (ram_we),
    .wstrb (req_wstrb),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

  assign o_rsp_rdata = (o_req_ack && !req_we && !req_oor) ? ram_rdata : '0;

`ifdef ASRV32_MEM_ERR_EN
  assign o_rsp_err = o_req_ack && req_oor;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      o_req_ack <= 1'b0;
      o_busy    <= 1'b0;
      req_we    <= 1'b0;
      req_idx   <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      req_oor   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req_stb) begin
            req_we    <= i_req_we;
            req_idx   <= acc_idx;
            req_wdata <= i_req_wdata;
            req_wstrb <= i_req_wstrb;
            req_oor   <= acc_oor;
            o_busy    <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
            end else begin
              state     <= ST_RESP;
              o_req_ack <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state     <= ST_RESP;
            o_req_ack <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          o_req_ack <= 1'b0;
          o_busy    <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          o_req_ack <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_asrv32_mem_responder.sv
// Self-checking bench for asrv32_mem_responder: WAIT_CYCLES=1 main instance plus WAIT_CYCLES=0/3
// instances for latency; follows ASRV32_MEM_ERR_EN when defined.
module tb_asrv32_mem_responder;

`ifdef ASRV32_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int UNIT_MAIN  = 0;
  localparam int UNIT_W0    = 1;
  localparam int UNIT_W3    = 2;
  localparam int ACK_BUDGET = 20;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb_m = 1'b0;
  logic        stb_0 = 1'b0;
  logic        stb_3 = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        ack_m, ack_0, ack_3;
  logic        busy_m, busy_0, busy_3;
  logic        err_m, err_0, err_3;
  logic [31:0] rdata_m, rdata_0, rdata_3;

  int assertions = 0;
  int failures   = 0;
  logic [31:0] mdl [1024];

  always #5 clk = ~clk;

  asrv32_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_stb(stb_m), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_req_ack(ack_m), .o_rsp_rdata(rdata_m), .o_busy(busy_m)
`ifdef ASRV32_MEM_ERR_EN
    , .o_rsp_err(err_m)
`endif
  );

  asrv32_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_w0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_stb(stb_0), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_req_ack(ack_0), .o_rsp_rdata(rdata_0), .o_busy(busy_0)
`ifdef ASRV32_MEM_ERR_EN
    , .o_rsp_err(err_0)
`endif
  );

  asrv32_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) dut_w3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_stb(stb_3), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_req_ack(ack_3), .o_rsp_rdata(rdata_3), .o_busy(busy_3)
`ifdef ASRV32_MEM_ERR_EN
    , .o_rsp_err(err_3)
`endif
  );

`ifndef ASRV32_MEM_ERR_EN
  assign err_m = 1'b0;
  assign err_0 = 1'b0;
  assign err_3 = 1'b0;
`endif

  // Reference memory: 1024 words at byte address 0, wrapping unless error reporting is on.
  function automatic bit model_in_range(input logic [31:0] a);
    return a < 32'h0000_1000;
  endfunction

  function automatic int model_index(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd1024);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (ERR_EN && !model_in_range(a)) return 32'h0;
    return mdl[model_index(a)];
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    if (ERR_EN && !model_in_range(a)) return;
    idx = model_index(a);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  function automatic logic ack_of(input int unit);
    case (unit)
      UNIT_W0: return ack_0;
      UNIT_W3: return ack_3;
      default: return ack_m;
    endcase
  endfunction

  function automatic logic busy_of(input int unit);
    case (unit)
      UNIT_W0: return busy_0;
      UNIT_W3: return busy_3;
      default: return busy_m;
    endcase
  endfunction

  function automatic logic err_of(input int unit);
    case (unit)
      UNIT_W0: return err_0;
      UNIT_W3: return err_3;
      default: return err_m;
    endcase
  endfunction

  function automatic logic [31:0] rdata_of(input int unit);
    case (unit)
      UNIT_W0: return rdata_0;
      UNIT_W3: return rdata_3;
      default: return rdata_m;
    endcase
  endfunction

  task automatic set_stb(input int unit, input logic v);
    case (unit)
      UNIT_W0: stb_0 = v;
      UNIT_W3: stb_3 = v;
      default: stb_m = v;
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called just after a negedge with the unit idle; returns just after a negedge with it idle again.
  task automatic applyStimulus(input int unit, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb,
                               output logic [31:0] rdata, output int lat, output logic err);
    bit got;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    set_stb(unit, 1'b1);
    @(posedge clk);
    got   = 1'b0;
    lat   = 0;
    rdata = '0;
    err   = 1'b0;
    for (int c = 1; c <= ACK_BUDGET && !got; c++) begin
      @(negedge clk);
      set_stb(unit, 1'b0);
      if (ack_of(unit)) begin
        got   = 1'b1;
        lat   = c;
        rdata = rdata_of(unit);
        err   = err_of(unit);
        checkOutput("busy_at_ack", 32'(busy_of(unit)), 32'd1);
      end
    end
    if (!got) begin
      assertions++;
      failures++;
      $display("[TB] FAIL ack_timeout: no ack within %0d cycles, one required", ACK_BUDGET);
    end
    @(negedge clk);
    checkOutput("ack_single_pulse", 32'(ack_of(unit)), 32'd0);
    checkOutput("busy_after_ack", 32'(busy_of(unit)), 32'd0);
  endtask

  task automatic checkedTxn(input string tag, input int unit, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb,
                            input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    int          lat;
    logic        er;
    applyStimulus(unit, we, addr, wdata, wstrb, rd, lat, er);
    checkOutput({tag, "_rdata"}, rd, exp_rdata);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (ERR_EN) checkOutput({tag, "_err"}, 32'(er), 32'(exp_err));
  endtask

  vec_t vecs [13];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          last_ack;
    int          nacks;
    logic [31:0] issued;
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [3:0]  s;

    vecs[0]  = '{1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h10, 32'h0000_00AA, 4'h1, 32'h0};
    vecs[3]  = '{1'b0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEAA};
    vecs[4]  = '{1'b1, 32'h10, 32'h1234_5678, 4'h0, 32'h0};
    vecs[5]  = '{1'b0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEAA};
    vecs[6]  = '{1'b0, 32'h13, 32'h0,         4'h0, 32'hDEAD_BEAA};
    vecs[7]  = '{1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0};
    vecs[8]  = '{1'b1, 32'h20, 32'hA5A5_A5A5, 4'hA, 32'h0};
    vecs[9]  = '{1'b0, 32'h20, 32'h0,         4'h0, 32'hA5FE_A50D};
    vecs[10] = '{1'b1, 32'h00, 32'h1122_3344, 4'hF, 32'h0};
    vecs[11] = '{1'b1, 32'h04, 32'h5566_7788, 4'hF, 32'h0};
    vecs[12] = '{1'b0, 32'h04, 32'h0,         4'h0, 32'h5566_7788};

    #2;
    checkOutput("reset_ack", 32'(ack_m), 32'd0);
    checkOutput("reset_busy", 32'(busy_m), 32'd0);
    checkOutput("reset_rdata", rdata_m, 32'd0);
    checkOutput("reset_err", 32'(err_m), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      checkedTxn($sformatf("vec%0d", i), UNIT_MAIN, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                 vecs[i].wstrb, vecs[i].exp_rdata, 1'b0, 2);
      if (vecs[i].we) model_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
    end

    $display("[TB] strobe held high, alternating 0x0/0x4");
    issued    = 32'h0;
    req_we    = 1'b0;
    req_addr  = issued;
    req_wstrb = 4'hF;
    req_wdata = 32'hBAD0_BAD0;
    stb_m     = 1'b1;
    last_ack  = -1;
    nacks     = 0;
    for (int c = 1; c <= 40 && nacks < 6; c++) begin
      @(negedge clk);
      if (ack_m) begin
        checkOutput("hold_rdata", rdata_m, model_read(issued));
        checkOutput("hold_busy", 32'(busy_m), 32'd1);
        if (last_ack >= 0) checkOutput("hold_interval", 32'(c - last_ack), 32'd3);
        last_ack = c;
        nacks++;
        issued   = issued ^ 32'h4;
        req_we   = 1'b0;
        req_addr = issued;
      end else if (busy_m) begin
        req_we   = 1'b1;
        req_addr = 32'h20;
      end
    end
    stb_m = 1'b0;
    checkOutput("hold_ack_count", 32'(nacks), 32'd6);
    @(negedge clk);
    @(negedge clk);

    checkedTxn("w0_wr",   UNIT_W0, 1'b1, 32'h8, 32'h600D_CAFE, 4'hF, 32'h0, 1'b0, 1);
    checkedTxn("w0_rd",   UNIT_W0, 1'b0, 32'h8, 32'h0,         4'h0, 32'h600D_CAFE, 1'b0, 1);
    checkedTxn("w3_wr",   UNIT_W3, 1'b1, 32'h8, 32'h600D_CAFE, 4'hF, 32'h0, 1'b0, 4);
    checkedTxn("w3_wr2",  UNIT_W3, 1'b1, 32'h8, 32'h1111_1111, 4'h6, 32'h0, 1'b0, 4);
    checkedTxn("w3_rd",   UNIT_W3, 1'b0, 32'h8, 32'h0,         4'h0, 32'h6011_11FE, 1'b0, 4);

    checkedTxn("oor_rd", UNIT_MAIN, 1'b0, 32'h1000, 32'h0, 4'h0, model_read(32'h1000), ERR_EN, 2);
    checkedTxn("oor_wr", UNIT_MAIN, 1'b1, 32'h1000, 32'hFFFF_0000, 4'hF, 32'h0, ERR_EN, 2);
    model_write(32'h1000, 32'hFFFF_0000, 4'hF);
    checkedTxn("word0_rd", UNIT_MAIN, 1'b0, 32'h0, 32'h0, 4'h0, model_read(32'h0), 1'b0, 2);

    // Reset in the middle of a write: the write must vanish and no ack may appear.
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h0BAD_F00D;
    req_wstrb = 4'hF;
    stb_m     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stb_m = 1'b0;
    checkOutput("midrst_busy_before", 32'(busy_m), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ack", 32'(ack_m), 32'd0);
    checkOutput("midrst_busy", 32'(busy_m), 32'd0);
    checkOutput("midrst_rdata", rdata_m, 32'd0);
    checkOutput("midrst_err", 32'(err_m), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("midrst_no_ack", 32'(ack_m), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkedTxn("midrst_read", UNIT_MAIN, 1'b0, 32'h20, 32'h0, 4'h0, 32'hA5FE_A50D, 1'b0, 2);

    for (int k = 0; k < 16; k++) begin
      d = $urandom;
      a = 32'h100 + 32'(4 * k);
      checkedTxn("init", UNIT_MAIN, 1'b1, a, d, 4'hF, 32'h0, 1'b0, 2);
      model_write(a, d, 4'hF);
    end
    for (int n = 0; n < 60; n++) begin
      w = 1'($urandom_range(0, 1));
      a = (($urandom_range(0, 7) == 0) ? 32'h1100 : 32'h100)
          + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      checkedTxn("rand", UNIT_MAIN, w, a, d, s, w ? 32'h0 : model_read(a),
                 ERR_EN && !model_in_range(a), 2);
      if (w) model_write(a, d, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
